// File: rtl/mem_scan_pkg.sv
// Shared constants for the memory scan controller: mode codes, FSM state
// encoding and a helper that sizes the auto-scan tick counter.
package mem_scan_pkg;

  // Mode request codes presented on the mode input
  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_CLEAR  = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  // Controller FSM state encoding
  localparam logic [1:0] ST_MANUAL = 2'b00;
  localparam logic [1:0] ST_SCAN   = 2'b01;
  localparam logic [1:0] ST_CLEAR  = 2'b10;

  // Width of a counter running 0..div-1; never narrower than one bit
  function automatic int tick_width(input int div);
    if (div <= 2) begin
      return 1;
    end else begin
      return $clog2(div);
    end
  endfunction

endpackage

// File: rtl/mem_scan_ctrl_if.sv
// Control/display bundle between the board-level logic and the controller.
interface mem_scan_ctrl_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 5
);

  logic [1:0]        mode;
  logic              start;
  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              busy;
  logic              done;

  // Board side: issues requests, observes the display pair
  modport master (
    output mode, start, wr_en, addr, wr_data,
    input  disp_addr, disp_data, busy, done
  );

  // Controller side
  modport slave (
    input  mode, start, wr_en, addr, wr_data,
    output disp_addr, disp_data, busy, done
  );

endinterface

// File: rtl/mem_scan_ctrl_sync_ram.sv
// Single-port synchronous RAM, one-cycle read latency. A read of the
// address being written returns the previous contents. No reset so the
// array maps onto block RAM.
module sync_ram #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              wren,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  // Write port and registered read port sharing one address
  always_ff @(posedge clock) begin
    if (wren) begin
      mem[address] <= data;
    end
    q <= mem[address];
  end

endmodule

// File: rtl/mem_scan_ctrl.sv
// Memory scan controller: manual read/write, timed auto-scan and bulk clear
// around a synchronous RAM, with an address/data display pair whose two
// halves always refer to the same word.
module mem_scan_ctrl
  import mem_scan_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 5,
  parameter int TICK_DIV = 25000000
) (
  input  logic            clock,
  input  logic            resetn,
  mem_scan_ctrl_if.slave  bus
);

  localparam int                TICK_W    = tick_width(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_p1_q, addr_p1_d;
  logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;

  logic              start_edge_s;
  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic [DATA_W-1:0] ram_q_s;

  assign start_edge_s = bus.start & ~start_q;

  sync_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock   (clock),
    .wren    (ram_we_s),
    .address (ram_addr_s),
    .data    (ram_wdata_s),
    .q       (ram_q_s)
  );

  // FSM, scan pointer and tick counter next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tick_d  = tick_q;
    done_d  = 1'b0;
    case (state_q)
      ST_MANUAL: begin
        if (start_edge_s) begin
          if (bus.mode == MODE_SCAN) begin
            state_d = ST_SCAN;
            ptr_d   = PTR_ZERO;
            tick_d  = TICK_ZERO;
          end else if (bus.mode == MODE_CLEAR) begin
            state_d = ST_CLEAR;
            ptr_d   = PTR_ZERO;
          end else begin
            // MANUAL and reserved requests do nothing
            state_d = ST_MANUAL;
          end
        end else begin
          state_d = ST_MANUAL;
        end
      end
      ST_SCAN: begin
        if ((bus.mode != MODE_SCAN) || start_edge_s) begin
          state_d = ST_MANUAL;
        end else if (tick_q == TICK_LAST) begin
          tick_d = TICK_ZERO;
          ptr_d  = ptr_q + PTR_ONE;
        end else begin
          tick_d = tick_q + TICK_ONE;
        end
      end
      ST_CLEAR: begin
        // Inputs are deliberately ignored until every word is zeroed
        ptr_d = ptr_q + PTR_ONE;
        if (ptr_q == PTR_LAST) begin
          state_d = ST_MANUAL;
          done_d  = 1'b1;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d = ST_MANUAL;
        ptr_d   = PTR_ZERO;
        tick_d  = TICK_ZERO;
      end
    endcase
    busy_d  = (state_d == ST_SCAN) || (state_d == ST_CLEAR);
    start_d = bus.start;
  end

  // RAM port steering: manual port in MANUAL, pointer otherwise
  always_comb begin
    ram_we_s    = 1'b0;
    ram_addr_s  = bus.addr;
    ram_wdata_s = bus.wr_data;
    case (state_q)
      ST_MANUAL: begin
        ram_we_s    = bus.wr_en;
        ram_addr_s  = bus.addr;
        ram_wdata_s = bus.wr_data;
      end
      ST_SCAN: begin
        ram_we_s    = 1'b0;
        ram_addr_s  = ptr_q;
        ram_wdata_s = {DATA_W{1'b0}};
      end
      ST_CLEAR: begin
        ram_we_s    = 1'b1;
        ram_addr_s  = ptr_q;
        ram_wdata_s = {DATA_W{1'b0}};
      end
      default: begin
        ram_we_s    = 1'b0;
        ram_addr_s  = bus.addr;
        ram_wdata_s = {DATA_W{1'b0}};
      end
    endcase
  end

  // Display pipeline: address delayed two stages to meet its registered data
  always_comb begin
    addr_p1_d   = ram_addr_s;
    disp_addr_d = addr_p1_q;
    disp_data_d = ram_q_s;
  end

  // Controller state registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_MANUAL;
      ptr_q       <= PTR_ZERO;
      tick_q      <= TICK_ZERO;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_p1_q   <= PTR_ZERO;
      disp_addr_q <= PTR_ZERO;
      disp_data_q <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      tick_q      <= tick_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      addr_p1_q   <= addr_p1_d;
      disp_addr_q <= disp_addr_d;
      disp_data_q <= disp_data_d;
    end
  end

  assign bus.disp_addr = disp_addr_q;
  assign bus.disp_data = disp_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
